// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state encoding and default operand width for serial_sub

package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// rtl/serial_sub_fs_cell.sv - 1-bit full subtractor / full adder cell (mode=1 selects add)

module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   input  logic mode,
   output logic d,
   output logic bo
);

   always_comb begin
      d = x ^ y ^ bi;
      if (mode) begin
         bo = (x & y) | ((x ^ y) & bi);
      end else begin
         bo = (~x & y) | (~(x ^ y) & bi);
      end
   end

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor (diff = a - b - bin), one bit per clock
// Optional add mode (add port) when SERIAL_SUB_ADD_EN is defined.

module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
`ifdef SERIAL_SUB_ADD_EN
   input  logic             add,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             cell_mode;
   logic             cell_d, cell_bo;
   logic             accept;

`ifdef SERIAL_SUB_ADD_EN
   logic mode_q, mode_d;

   always_comb begin
      mode_d = mode_q;
      if (accept) begin
         mode_d = add;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end

   assign cell_mode = mode_q;
`else
   assign cell_mode = 1'b0;
`endif

   fs_cell u_cell (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bi   (br_q),
      .mode (cell_mode),
      .d    (cell_d),
      .bo   (cell_bo)
   );

   // SHIFT holds WIDTH compute cycles plus one terminal cycle where cnt_q == WIDTH
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = DONE;
               diff_d  = res_q;
               bout_d  = br_q;
            end else begin
               a_d   = a_q >> 1;
               b_d   = b_q >> 1;
               br_d  = cell_bo;
               res_d = {cell_d, res_q[WIDTH-1:1]};
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (start) begin
               accept = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
         a_d     = a;
         b_d     = b;
         br_d    = bin;
         res_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed self-checking bench for serial_sub (WIDTH=8)

module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         add;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int checks;
   int fails;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
`ifdef SERIAL_SUB_ADD_EN
      .add   (add),
`endif
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start for one edge; returns after the accepting edge
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input logic ad);
      a = av; b = bv; bin = bi; add = ad; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges from just after the accepting edge until done, bounded
   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 9);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input logic ad, input logic [W-1:0] ed, input logic eb);
      int n;
      launch(av, bv, bi, ad);
      chk({tag, "_busy"}, busy, 1);
      a = ~av; b = ~bv; bin = ~bi;
      wait_done(tag, n);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_bout"}, bout, eb);
      chk({tag, "_busy_done"}, busy, 0);
      tick();
      chk({tag, "_done_1cyc"}, done, 0);
      chk({tag, "_hold"}, diff, ed);
   endtask

   initial begin
      int n;
      checks = 0; fails = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0; add = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      run_op("t1", 8'h3C, 8'h15, 1'b0, 1'b0, 8'h27, 1'b0);
      run_op("t2", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
      run_op("t3", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
      run_op("t4", 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);

      // back-to-back: start held during the DONE cycle
      launch(8'h80, 8'h7F, 1'b1, 1'b0);
      wait_done("b2b_a", n);
      chk("b2b_a_diff", diff, 8'h00);
      chk("b2b_a_bout", bout, 0);
      a = 8'h05; b = 8'h07; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_restart_busy", busy, 1);
      chk("b2b_no_extra_done", done, 0);
      chk("b2b_diff_held", diff, 8'h00);
      wait_done("b2b_b", n);
      chk("b2b_b_diff", diff, 8'hFE);
      chk("b2b_b_bout", bout, 1);
      tick();

      // start re-pulsed in SHIFT is ignored
      launch(8'hAA, 8'h55, 1'b0, 1'b0);
      n = 0;
      while (!done && n < 20) begin
         if (n == 3) begin
            start = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk("ign_latency", n, 9);
      chk("ign_diff", diff, 8'h55);
      chk("ign_bout", bout, 0);
      tick();
      chk("ign_no_requeue", busy, 0);
      chk("ign_no_done", done, 0);

      // reset mid-operation aborts without a done pulse
      launch(8'h10, 8'h01, 1'b0, 1'b0);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bout", bout, 0);
      tick();
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done || busy) n++;
      end
      chk("abort_quiet", n, 0);
      run_op("fresh", 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
      run_op("add1", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
      run_op("add2", 8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0);
      run_op("sub_after_add", 8'h3C, 8'h15, 1'b0, 1'b0, 8'h27, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
